goertzel_tone_detector: RTL
===========================

# goertzel_tone_detector

Single-bin Goertzel tone detector: the analysis counterpart of the sine generators. It consumes signed 8-bit audio samples at the sample strobe rate and accumulates one N-sample block. At the end of each block it computes the squared magnitude of one DFT bin and compares it against a threshold. It sits in the transcription front end after sample capture; one instance per detected note.

## Interface
- `N`, default 64: samples per block, 2..1024.
- `COEFF`, default 30274: 2·cos(2πk/N) in signed Q2.14, 16-bit. The default is bin 4 of 64, i.e. 750 Hz at a 12 kHz sample rate.
- `SW`, default 24: signed width of the Goertzel state registers s1 and s2.
- `THRESHOLD`, default 4194304: power at or above this value flags the tone.

- `clk_in`, input, 1: system clock.
- `rst_in`, input, 1: synchronous, active-high reset.
- `sample_valid_in`, input, 1: one-cycle sample strobe.
- `sample_in`, input, 8: signed two's-complement audio sample.
- `power_out`, output, 48: unsigned bin power, held between blocks.
- `power_valid_out`, output, 1: one-cycle pulse when `power_out` updates.
- `tone_detected_out`, output, 1: `power_out >= THRESHOLD`; updates with `power_valid_out`.
- `sample_dropped_out`, output, 1: one-cycle pulse when a strobed sample is ignored.

## Operation
- FSM states: ACCUM, P_SQ1, P_SQ2, P_CROSS, P_OUT.
- ACCUM, on `sample_valid_in`:
  - s0 = sext(sample_in) + ((COEFF·s1) >>> 14) − s2.
  - Then s2 ← s1, s1 ← s0, count ← count+1.
  - The shift is arithmetic, truncating toward −∞.
- The sample accepted with count == N−1 goes to P_SQ1 and clears count.
- P_SQ1: a ← s1·s1.
- P_SQ2: b ← s2·s2.
- P_CROSS: c ← ((COEFF·s1) >>> 14)·s2.
- P_OUT:
  - p = a + b − c, computed at 2·SW+2 bits signed.
  - Clamp p < 0 to 0 and p > 2^48−1 to 2^48−1, then register it to `power_out`.
  - Pulse `power_valid_out`, register `tone_detected_out`.
  - Clear s1 and s2, return to ACCUM.
- A `sample_valid_in` seen in any P_* state is discarded. `sample_dropped_out` pulses the next cycle. That sample does not count toward the next block.
- The next block starts from zeroed state. There is no block overlap and no windowing.

## Timing
- Reset values:
  - `power_out` = 0, `power_valid_out` = 0, `tone_detected_out` = 0, `sample_dropped_out` = 0.
  - s1 = s2 = 0, count = 0, state = ACCUM.
- Latency: `power_valid_out` is high in the cycle following the 4th rising edge after the edge that accepted the Nth sample. It is high for exactly one cycle.
- `power_out` and `tone_detected_out` are stable from that cycle until the next `power_valid_out`.
- Minimum block-to-block period is N strobes plus 4 cycles. The first sample of the next block may arrive in the cycle `power_valid_out` is high.
- Reset mid-block or mid-power:
  - Everything returns to reset values the next cycle.
  - No `power_valid_out` is emitted for the aborted block.
- Strobe and reset in the same cycle: reset wins and the sample is not counted.

## Configuration
- `GOERTZEL_SAT_EN` defined: every s0 update saturates to [−2^(SW−1), 2^(SW−1)−1].
- `GOERTZEL_SAT_EN` undefined: s0 wraps modulo 2^SW.
- Power-stage clamping is always present and does not depend on the macro.

## Structure
- Package `goertzel_pkg` holds:
  - the FSM state enum;
  - `COEFF_FRAC` = 14;
  - `POWER_W` = 48;
  - the default 750 Hz coefficient `COEFF_750_12K` = 30274.
- Sub-module `goertzel_power`:
  - takes s1, s2 and COEFF;
  - runs the P_SQ1..P_OUT sequence with a single shared multiplier;
  - start/done handshake with the accumulator.

## Test plan
- Reset: assert `rst_in` for 2 cycles → all outputs 0; 64 strobes later the first `power_valid_out` appears.
- On-bin tone: 64 samples of round(127·sin(2πn/16)) → `power_out` ≈ 1.65e7 (±1%), `tone_detected_out` = 1, valid pulse exactly 4 edges after the 64th accept.
- Silence then DC:
  - 64 zeros → `power_out` = 0, `tone_detected_out` = 0.
  - Then 64 samples of 100 → `power_out` < THRESHOLD, `tone_detected_out` = 0.
- Drop and abort:
  - Strobe in each of the 4 power cycles → 4 `sample_dropped_out` pulses, and the next block still needs 64 accepted samples.
  - `rst_in` after 30 samples → no valid pulse; power appears only after 64 fresh samples.
- Saturation with SW = 16, COEFF = 32767, 64 samples of 127:
  - with `GOERTZEL_SAT_EN` → s1 pinned at 32767 from about sample 23 on;
  - without it → s1 wraps negative;
  - both builds → `power_out` lies in [0, 2^48−1].

Source files
------------

// File: rtl/goertzel_pkg.sv
// Shared types and constants for the single-bin Goertzel tone detector.
package goertzel_pkg;

  typedef enum logic [2:0] {
    ACCUM,
    P_SQ1,
    P_SQ2,
    P_CROSS,
    P_OUT
  } state_e;

  localparam int                 COEFF_FRAC    = 14;
  localparam int                 POWER_W       = 48;
  localparam logic signed [15:0] COEFF_750_12K = 16'sd30274;

endpackage

// File: rtl/goertzel_power.sv
// Block-end power stage: a = s1^2, b = s2^2, c = ((COEFF*s1)>>>14)*s2, then
// p = a + b - c clamped to the 48-bit output range. One shared multiplier.
module goertzel_power
  import goertzel_pkg::*;
#(
  parameter int                 SW        = 24,
  parameter logic signed [15:0] COEFF     = COEFF_750_12K,
  parameter logic [POWER_W-1:0] THRESHOLD = 48'd4194304
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic signed [SW-1:0] s1_in,
  input  logic signed [SW-1:0] s2_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [POWER_W-1:0]   power_out,
  output logic                 power_valid_out,
  output logic                 tone_detected_out
);
  localparam int PW = 2 * SW + 2;
  localparam int CW = (PW > POWER_W + 1) ? PW : POWER_W + 1;
  localparam int MW = SW + 2;
  localparam logic signed [CW-1:0] P_MAX = CW'({POWER_W{1'b1}});

  state_e                  state_q, state_d;
  logic signed [PW-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
  logic [POWER_W-1:0]      power_q, power_d;
  logic                    valid_q, valid_d, tone_q, tone_d;

  logic signed [SW+15:0]   cprod;
  logic signed [MW-1:0]    cs1, mul_x, mul_y;
  logic signed [2*MW-1:0]  mul_p;
  logic signed [PW-1:0]    p;
  logic signed [CW-1:0]    p_ext;
  logic [POWER_W-1:0]      power_sat;

  always_comb begin
    cprod = (SW+16)'(COEFF) * (SW+16)'(s1_in);
    cs1   = MW'(cprod >>> COEFF_FRAC);

    // Operand mux feeding the single multiplier, selected by power phase.
    mul_x = MW'(s1_in);
    mul_y = MW'(s1_in);
    case (state_q)
      P_SQ2:   begin mul_x = MW'(s2_in); mul_y = MW'(s2_in); end
      P_CROSS: begin mul_x = cs1;        mul_y = MW'(s2_in); end
      default: ;
    endcase
    mul_p = (2*MW)'(mul_x) * (2*MW)'(mul_y);

    p     = a_q + b_q - c_q;
    p_ext = CW'(p);
    if (p_ext[CW-1])        power_sat = '0;
    else if (p_ext > P_MAX) power_sat = '1;
    else                    power_sat = p_ext[POWER_W-1:0];

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    power_d = power_q;
    tone_d  = tone_q;
    valid_d = 1'b0;
    case (state_q)
      ACCUM:   if (start_in) state_d = P_SQ1;
      P_SQ1:   begin a_d = PW'(mul_p); state_d = P_SQ2;   end
      P_SQ2:   begin b_d = PW'(mul_p); state_d = P_CROSS; end
      P_CROSS: begin c_d = PW'(mul_p); state_d = P_OUT;   end
      P_OUT: begin
        power_d = power_sat;
        tone_d  = (power_sat >= THRESHOLD);
        valid_d = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ACCUM;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      power_q <= '0;
      valid_q <= 1'b0;
      tone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      power_q <= power_d;
      valid_q <= valid_d;
      tone_q  <= tone_d;
    end
  end

  assign busy_out          = (state_q != ACCUM);
  assign done_out          = (state_q == P_OUT);
  assign power_out         = power_q;
  assign power_valid_out   = valid_q;
  assign tone_detected_out = tone_q;

endmodule

// File: rtl/goertzel_tone_detector.sv
// Single-bin Goertzel tone detector: N-sample accumulation then power/threshold.
// Define GOERTZEL_SAT_EN to saturate the s0 update instead of wrapping.
module goertzel_tone_detector
  import goertzel_pkg::*;
#(
  parameter int                 N         = 64,
  parameter logic signed [15:0] COEFF     = COEFF_750_12K,
  parameter int                 SW        = 24,
  parameter logic [POWER_W-1:0] THRESHOLD = 48'd4194304
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               sample_valid_in,
  input  logic signed [7:0]  sample_in,
  output logic [POWER_W-1:0] power_out,
  output logic               power_valid_out,
  output logic               tone_detected_out,
  output logic               sample_dropped_out
);
  localparam int              CNTW = $clog2(N);
  localparam int              XW   = SW + 4;
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

`ifdef GOERTZEL_SAT_EN
  localparam logic signed [XW-1:0] S_MAX = XW'({1'b0, {(SW-1){1'b1}}});
  localparam logic signed [XW-1:0] S_MIN = ~S_MAX;
`endif

  logic signed [SW-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  dropped_q, dropped_d;
  logic                  busy, done, start, accept;
  logic signed [SW+15:0] cprod;
  logic signed [XW-1:0]  s0_wide;
  logic signed [SW-1:0]  s0;

  always_comb begin
    accept  = sample_valid_in && !busy;
    cprod   = (SW+16)'(COEFF) * (SW+16)'(s1_q);
    s0_wide = XW'(sample_in) + XW'(cprod >>> COEFF_FRAC) - XW'(s2_q);
`ifdef GOERTZEL_SAT_EN
    if (s0_wide > S_MAX)      s0 = SW'(S_MAX);
    else if (s0_wide < S_MIN) s0 = SW'(S_MIN);
    else                      s0 = SW'(s0_wide);
`else
    s0 = SW'(s0_wide);
`endif

    s1_d      = s1_q;
    s2_d      = s2_q;
    count_d   = count_q;
    start     = 1'b0;
    dropped_d = sample_valid_in && busy;
    if (accept) begin
      s2_d = s1_q;
      s1_d = s0;
      if (count_q == LAST) begin
        count_d = '0;
        start   = 1'b1;
      end else begin
        count_d = count_q + CNTW'(1);
      end
    end
    // State is held through the power phases and zeroed as the result lands.
    if (done) begin
      s1_d = '0;
      s2_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q      <= '0;
      s2_q      <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  goertzel_power #(
    .SW        (SW),
    .COEFF     (COEFF),
    .THRESHOLD (THRESHOLD)
  ) u_power (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .start_in          (start),
    .s1_in             (s1_q),
    .s2_in             (s2_q),
    .busy_out          (busy),
    .done_out          (done),
    .power_out         (power_out),
    .power_valid_out   (power_valid_out),
    .tone_detected_out (tone_detected_out)
  );

  assign sample_dropped_out = dropped_q;

endmodule
